// File: rtl/bounce_pattern_decoder.sv
// Purpose: decode a bouncing one-hot pattern into position/direction, lock onto the sweep, flag errors.
// Latency: 1 cycle; every output is registered and reflects the sample captured on the previous edge.
// Backpressure: none; q_in is only evaluated when ena=1. Optional error counter: BOUNCE_DEC_ERRCNT_EN.
module bounce_pattern_decoder #(
   parameter int N          = 8,   // pattern width, >= 3
   parameter int CNT_W      = 8,   // period_count width
   parameter int LOCK_COUNT = 2    // consecutive consistent steps to lock, 1..15
) (
   input  logic                   clk,
   input  logic                   rstna,
   input  logic                   ena,
   input  logic [N-1:0]           q_in,
   output logic [$clog2(N)-1:0]   pos,
   output logic                   dir,
   output logic                   locked,
   output logic                   tc,
   output logic [CNT_W-1:0]       period_count,
   output logic                   err,
   output logic                   onehot_err
`ifdef BOUNCE_DEC_ERRCNT_EN
   ,
   input  logic                   err_clr,
   output logic [7:0]             err_count
`else
`endif
);

   localparam int PW = $clog2(N);

   localparam logic [1:0] SEARCH  = 2'd0;
   localparam logic [1:0] ACQUIRE = 2'd1;
   localparam logic [1:0] LOCKED  = 2'd2;

   localparam logic [N-1:0] ONE_N  = {{(N-1){1'b0}}, 1'b1};
   localparam logic [3:0]   LOCK_N = 4'(LOCK_COUNT);

   logic [1:0]       state;
   logic [3:0]       match_cnt;

   logic             valid;
   logic [PW-1:0]    idx;
   logic [PW-1:0]    exp_pos;
   logic             exp_dir;
   logic             adj_up;
   logic             adj_dn;
   logic             hit;

   logic [1:0]       nxt_state;
   logic [PW-1:0]    nxt_pos;
   logic             nxt_dir;
   logic [3:0]       nxt_mc;
   logic [CNT_W-1:0] nxt_pc;
   logic             nxt_tc;
   logic             nxt_err;
   logic             nxt_oh;

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
   assign valid = (q_in != '0) && ((q_in & (q_in - ONE_N)) == '0);

   // Binary index of the set bit (only meaningful when valid).
   always_comb begin
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (q_in[i]) idx = PW'(i);
      end
   end

   // Next position the generator should produce, turning around at either end.
   always_comb begin
      exp_pos = pos;
      exp_dir = dir;
      if (dir) begin
         if (pos == '0) begin
            exp_pos = PW'(1);
            exp_dir = 1'b0;
         end else begin
            exp_pos = pos - PW'(1);
            exp_dir = 1'b1;
         end
      end else begin
         if (pos == PW'(N-1)) begin
            exp_pos = PW'(N-2);
            exp_dir = 1'b1;
         end else begin
            exp_pos = pos + PW'(1);
            exp_dir = 1'b0;
         end
      end
   end

   // Adjacency is compared one bit wider so pos=N-1 (+1) cannot alias to index 0.
   assign adj_up = ({1'b0, idx} == ({1'b0, pos} + (PW+1)'(1)));
   assign adj_dn = (({1'b0, idx} + (PW+1)'(1)) == {1'b0, pos});
   assign hit    = valid && (idx == exp_pos);

   // Tracking state machine: search for a valid sample, acquire consistent steps, then police the sweep.
   always_comb begin
      nxt_state = state;
      nxt_pos   = pos;
      nxt_dir   = dir;
      nxt_mc    = match_cnt;
      nxt_pc    = period_count;
      nxt_tc    = 1'b0;
      nxt_err   = 1'b0;
      nxt_oh    = 1'b0;
      if (ena) begin
         nxt_oh = !valid;
         case (state)
            SEARCH: begin
               if (valid) begin
                  nxt_pos   = idx;
                  nxt_mc    = '0;
                  nxt_state = ACQUIRE;
               end
            end
            ACQUIRE: begin
               if (!valid) begin
                  nxt_state = SEARCH;
                  nxt_mc    = '0;
               end else if (match_cnt == '0) begin
                  // First step only establishes a direction from any neighbour.
                  nxt_pos = idx;
                  if (adj_up || adj_dn) begin
                     nxt_dir = adj_dn;
                     nxt_mc  = 4'd1;
                     if (LOCK_N == 4'd1) nxt_state = LOCKED;
                  end
               end else if (hit) begin
                  nxt_pos = exp_pos;
                  nxt_dir = exp_dir;
                  nxt_mc  = match_cnt + 4'd1;
                  if ((match_cnt + 4'd1) == LOCK_N) nxt_state = LOCKED;
               end else begin
                  nxt_pos = idx;
                  nxt_mc  = '0;
               end
            end
            LOCKED: begin
               if (hit) begin
                  nxt_pos = exp_pos;
                  nxt_dir = exp_dir;
                  if (idx == '0) begin
                     nxt_tc = 1'b1;
                     nxt_pc = period_count + CNT_W'(1);
                  end
               end else begin
                  // Any deviation, including a stalled repeat, drops lock.
                  nxt_err = 1'b1;
                  nxt_mc  = '0;
                  if (valid) begin
                     nxt_pos   = idx;
                     nxt_state = ACQUIRE;
                  end else begin
                     nxt_state = SEARCH;
                  end
               end
            end
            default: begin
               nxt_state = SEARCH;
               nxt_mc    = '0;
            end
         endcase
      end
   end

   // Register state and all outputs.
   always_ff @(posedge clk or negedge rstna) begin
      if (!rstna) begin
         state        <= SEARCH;
         pos          <= '0;
         dir          <= 1'b1;
         match_cnt    <= '0;
         period_count <= '0;
         tc           <= 1'b0;
         err          <= 1'b0;
         onehot_err   <= 1'b0;
      end else begin
         state        <= nxt_state;
         pos          <= nxt_pos;
         dir          <= nxt_dir;
         match_cnt    <= nxt_mc;
         period_count <= nxt_pc;
         tc           <= nxt_tc;
         err          <= nxt_err;
         onehot_err   <= nxt_oh;
      end
   end

   assign locked = (state == LOCKED);

`ifdef BOUNCE_DEC_ERRCNT_EN
   // Saturating error counter; updates on the same edge the err/onehot_err pulse is raised, clear wins.
   always_ff @(posedge clk or negedge rstna) begin
      if (!rstna) begin
         err_count <= '0;
      end else if (err_clr) begin
         err_count <= '0;
      end else if ((nxt_err || nxt_oh) && (err_count != 8'hFF)) begin
         err_count <= err_count + 8'd1;
      end
   end
`else
   // Error counter not built.
`endif

endmodule

// File: tb/tb_bounce_pattern_decoder.sv
// Bench for bounce_pattern_decoder: reference model feeds a scoreboard queue, monitor pops and compares.
// Inputs change on the falling edge; outputs are sampled 1-2 time units after the rising edge.
// Two instances share stimulus: default widths and CNT_W=2 for wrap behaviour.
module tb_bounce_pattern_decoder;

   localparam int N  = 8;
   localparam int LC = 2;

   logic       clk = 1'b0;
   logic       rstna;
   logic       ena;
   logic [7:0] q_in;
   logic       err_clr;

   logic [2:0] pos;
   logic       dir, locked, tc, err, onehot_err;
   logic [7:0] period_count;
   logic [7:0] err_count;

   logic [2:0] w_pos;
   logic       w_dir, w_locked, w_tc, w_err, w_onehot_err;
   logic [1:0] w_period_count;
   logic [7:0] w_err_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bounce_pattern_decoder #(.N(N), .CNT_W(8), .LOCK_COUNT(LC)) dut (
      .clk(clk), .rstna(rstna), .ena(ena), .q_in(q_in),
      .pos(pos), .dir(dir), .locked(locked), .tc(tc),
      .period_count(period_count), .err(err), .onehot_err(onehot_err)
`ifdef BOUNCE_DEC_ERRCNT_EN
      , .err_clr(err_clr), .err_count(err_count)
`endif
   );

   bounce_pattern_decoder #(.N(N), .CNT_W(2), .LOCK_COUNT(LC)) dut_w (
      .clk(clk), .rstna(rstna), .ena(ena), .q_in(q_in),
      .pos(w_pos), .dir(w_dir), .locked(w_locked), .tc(w_tc),
      .period_count(w_period_count), .err(w_err), .onehot_err(w_onehot_err)
`ifdef BOUNCE_DEC_ERRCNT_EN
      , .err_clr(err_clr), .err_count(w_err_count)
`endif
   );

`ifndef BOUNCE_DEC_ERRCNT_EN
   assign err_count   = 8'd0;
   assign w_err_count = 8'd0;
`endif

   typedef struct {
      int pos; bit dir; bit locked; bit tc; int pc; bit err; bit oh; int ec;
   } exp_t;

   exp_t sbq[$];

   // Reference model state (0=search, 1=acquire, 2=locked)
   int m_state, m_pos, m_mc, m_pc, m_ec;
   bit m_dir;

   task automatic model_reset();
      m_state = 0; m_pos = 0; m_dir = 1; m_mc = 0; m_pc = 0; m_ec = 0;
      sbq.delete();
   endtask

   task automatic model_step(bit e, logic [7:0] q, bit clr);
      exp_t x;
      int ones, idx, ep;
      bit ed, valid, hit;
      x.tc = 0; x.err = 0; x.oh = 0;
      if (e) begin
         ones = 0; idx = 0;
         for (int i = 0; i < N; i++) if (q[i]) begin ones++; idx = i; end
         valid = (ones == 1);
         x.oh = !valid;
         if (m_dir) begin
            if (m_pos == 0) begin ep = 1; ed = 0; end else begin ep = m_pos - 1; ed = 1; end
         end else begin
            if (m_pos == N-1) begin ep = N-2; ed = 1; end else begin ep = m_pos + 1; ed = 0; end
         end
         hit = valid && (idx == ep);
         case (m_state)
            0: if (valid) begin m_pos = idx; m_mc = 0; m_state = 1; end
            1: begin
               if (!valid) begin
                  m_state = 0; m_mc = 0;
               end else if (m_mc == 0) begin
                  if (idx - m_pos == 1 || m_pos - idx == 1) begin
                     m_dir = (idx < m_pos); m_mc = 1;
                  end
                  m_pos = idx;
               end else if (hit) begin
                  m_pos = ep; m_dir = ed; m_mc++;
               end else begin
                  m_pos = idx; m_mc = 0;
               end
               if (m_state == 1 && m_mc == LC) m_state = 2;
            end
            default: begin
               if (hit) begin
                  m_pos = ep; m_dir = ed;
                  if (idx == 0) begin x.tc = 1; m_pc++; end
               end else begin
                  x.err = 1; m_mc = 0;
                  if (valid) begin m_pos = idx; m_state = 1; end else m_state = 0;
               end
            end
         endcase
      end
      if (clr) m_ec = 0;
      else if ((x.err || x.oh) && m_ec < 255) m_ec++;
      x.pos = m_pos; x.dir = m_dir; x.locked = (m_state == 2); x.pc = m_pc; x.ec = m_ec;
      sbq.push_back(x);
   endtask

   // Drive one cycle of stimulus on the falling edge and record what the model expects.
   task automatic step(bit e, logic [7:0] q, bit clr = 1'b0);
      @(negedge clk);
      ena = e; q_in = q; err_clr = clr;
      model_step(e, q, clr);
      @(posedge clk);
      #2;
   endtask

   // Monitor: compare every registered output against the scoreboard entry for that edge.
   always @(posedge clk) begin
      exp_t x;
      #1;
      if (rstna && sbq.size() > 0) begin
         x = sbq.pop_front();
         n_checks++;
         if (pos !== 3'(x.pos) || dir !== x.dir || locked !== x.locked || tc !== x.tc ||
             err !== x.err || onehot_err !== x.oh || period_count !== 8'(x.pc)) begin
            n_fail++;
            $display("FAIL sb_main t=%0t: got pos=%0d dir=%0b lk=%0b tc=%0b err=%0b oh=%0b pc=%0d want pos=%0d dir=%0b lk=%0b tc=%0b err=%0b oh=%0b pc=%0d",
                     $time, pos, dir, locked, tc, err, onehot_err, period_count,
                     x.pos, x.dir, x.locked, x.tc, x.err, x.oh, x.pc);
         end
         n_checks++;
         if (w_period_count !== 2'(x.pc) || w_tc !== x.tc || w_locked !== x.locked) begin
            n_fail++;
            $display("FAIL sb_narrow t=%0t: got pc=%0d tc=%0b lk=%0b want pc=%0d tc=%0b lk=%0b",
                     $time, w_period_count, w_tc, w_locked, 2'(x.pc), x.tc, x.locked);
         end
`ifdef BOUNCE_DEC_ERRCNT_EN
         n_checks++;
         if (err_count !== 8'(x.ec)) begin
            n_fail++;
            $display("FAIL sb_errcnt t=%0t: got %0d want %0d", $time, err_count, x.ec);
         end
`endif
      end
   end

   task automatic test_reset();
      rstna = 1'b0; ena = 1'b0; q_in = 8'h00; err_clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (pos !== 3'd0 || dir !== 1'b1 || locked !== 1'b0 || tc !== 1'b0 ||
          err !== 1'b0 || onehot_err !== 1'b0 || period_count !== 8'd0 || err_count !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_values: got pos=%0d dir=%0b lk=%0b tc=%0b err=%0b oh=%0b pc=%0d ec=%0d want 0 1 0 0 0 0 0 0",
                  pos, dir, locked, tc, err, onehot_err, period_count, err_count);
      end
      @(negedge clk);
      rstna = 1'b1;
   endtask

   task automatic test_lock();
      step(1, 8'h80);
      step(1, 8'h40);
      n_checks++;
      if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early: got %0b want 0", locked); end
      step(1, 8'h20);
      n_checks++;
      if (locked !== 1'b1 || pos !== 3'd5 || dir !== 1'b1 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL lock_acquire: got lk=%0b pos=%0d dir=%0b err=%0b want 1 5 1 0", locked, pos, dir, err);
      end
   endtask

   task automatic test_sweep();
      logic [7:0] seq [4];
      seq = '{8'h10, 8'h08, 8'h04, 8'h02};
      foreach (seq[i]) begin
         step(1, seq[i]);
         n_checks++;
         if (tc !== 1'b0) begin n_fail++; $display("FAIL sweep_no_tc: got %0b want 0", tc); end
      end
      step(1, 8'h01);
      n_checks++;
      if (tc !== 1'b1 || period_count !== 8'd1) begin
         n_fail++;
         $display("FAIL sweep_tc: got tc=%0b pc=%0d want 1 1", tc, period_count);
      end
      step(1, 8'h02);
      n_checks++;
      if (tc !== 1'b0 || dir !== 1'b0 || err !== 1'b0 || locked !== 1'b1) begin
         n_fail++;
         $display("FAIL sweep_turn: got tc=%0b dir=%0b err=%0b lk=%0b want 0 0 0 1", tc, dir, err, locked);
      end
   endtask

   task automatic test_error_inject();
      logic [7:0] seq [10];
      seq = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08};
      foreach (seq[i]) step(1, seq[i]);
      step(1, 8'h18);
      n_checks++;
      if (onehot_err !== 1'b1 || err !== 1'b1 || locked !== 1'b0) begin
         n_fail++;
         $display("FAIL inject_err: got oh=%0b err=%0b lk=%0b want 1 1 0", onehot_err, err, locked);
      end
      step(1, 8'h04);
      step(1, 8'h02);
      step(1, 8'h01);
      n_checks++;
      if (locked !== 1'b1 || tc !== 1'b0 || period_count !== 8'd1 || pos !== 3'd0) begin
         n_fail++;
         $display("FAIL inject_relock: got lk=%0b tc=%0b pc=%0d pos=%0d want 1 0 1 0", locked, tc, period_count, pos);
      end
   endtask

   task automatic test_hold();
      for (int i = 0; i < 5; i++) begin
         step(0, 8'($urandom));
         n_checks++;
         if (pos !== 3'd0 || dir !== 1'b1 || period_count !== 8'd1 || tc !== 1'b0 ||
             err !== 1'b0 || onehot_err !== 1'b0 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_%0d: got pos=%0d dir=%0b pc=%0d tc=%0b err=%0b oh=%0b lk=%0b want 0 1 1 0 0 0 1",
                     i, pos, dir, period_count, tc, err, onehot_err, locked);
         end
      end
   endtask

   // Continuous bounce from (gp, gd); checks tc lands exactly every 14 samples after start_off.
   task automatic run_bounce(int count, int gp_in, bit gd_in, int first_tc);
      int gp; bit gd;
      gp = gp_in; gd = gd_in;
      for (int k = 1; k <= count; k++) begin
         if (gd) begin
            if (gp == 0) begin gp = 1; gd = 0; end else gp--;
         end else begin
            if (gp == N-1) begin gp = N-2; gd = 1; end else gp++;
         end
         step(1, 8'(1 << gp));
         n_checks++;
         if (tc !== (k >= first_tc && (k - first_tc) % (2*(N-1)) == 0) || err !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_k%0d: got tc=%0b err=%0b want tc=%0b err=0", k, tc, err,
                     (k >= first_tc && (k - first_tc) % (2*(N-1)) == 0));
         end
      end
   endtask

   task automatic test_back_to_back();
      run_bounce(42, 0, 1'b1, 14);
      n_checks++;
      if (period_count !== 8'd4 || w_period_count !== 2'd0) begin
         n_fail++;
         $display("FAIL periods_3: got pc=%0d narrow=%0d want 4 0", period_count, w_period_count);
      end
   endtask

   task automatic test_stall();
      step(1, 8'h01);
      n_checks++;
      if (err !== 1'b1 || locked !== 1'b0 || onehot_err !== 1'b0 || pos !== 3'd0) begin
         n_fail++;
         $display("FAIL stall: got err=%0b lk=%0b oh=%0b pos=%0d want 1 0 0 0", err, locked, onehot_err, pos);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      #2;
      rstna = 1'b0;
      #1;
      n_checks++;
      if (pos !== 3'd0 || dir !== 1'b1 || locked !== 1'b0 || period_count !== 8'd0 ||
          w_period_count !== 2'd0 || err !== 1'b0 || onehot_err !== 1'b0 || tc !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: got pos=%0d dir=%0b lk=%0b pc=%0d npc=%0d err=%0b oh=%0b tc=%0b want 0 1 0 0 0 0 0 0",
                  pos, dir, locked, period_count, w_period_count, err, onehot_err, tc);
      end
      model_reset();
      @(negedge clk);
      rstna = 1'b1;
   endtask

   task automatic test_wrap();
      step(1, 8'h80);
      step(1, 8'h40);
      step(1, 8'h20);
      run_bounce(61, 5, 1'b1, 5);
      n_checks++;
      if (period_count !== 8'd5 || w_period_count !== 2'd1) begin
         n_fail++;
         $display("FAIL wrap_5: got pc=%0d narrow=%0d want 5 1", period_count, w_period_count);
      end
   endtask

`ifdef BOUNCE_DEC_ERRCNT_EN
   task automatic test_errcnt();
      for (int i = 0; i < 300; i++) step(1, 8'h00);
      n_checks++;
      if (err_count !== 8'd255) begin
         n_fail++;
         $display("FAIL errcnt_sat: got %0d want 255", err_count);
      end
      step(0, 8'h00, 1'b1);
      n_checks++;
      if (err_count !== 8'd0) begin
         n_fail++;
         $display("FAIL errcnt_clr: got %0d want 0", err_count);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_lock();
      test_sweep();
      test_error_inject();
      test_hold();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      test_wrap();
`ifdef BOUNCE_DEC_ERRCNT_EN
      test_errcnt();
`endif
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
